// File: rtl/lsu_ctrl_if.sv
// Request, response and memory-port bundle of the load/store sequencer.
// master = requester plus memory model, slave = lsu_ctrl.
interface lsu_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_byte_enable;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_fault,
        input  mem_read, mem_write, mem_addr, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_fault,
        output mem_read, mem_write, mem_addr, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: byte enables, lane-shifted store data, extended load data.
// Define MISALIGN_SPLIT_EN to split boundary-crossing accesses into two beats; otherwise misaligned accesses fault.
module lsu_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input logic      clk,
    input logic      rst,
    lsu_ctrl_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int SPN_W = OFF_W + 2;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t state_q, state_d;

    logic              store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] beat0_q;
    logic [DATA_W-1:0] beat1_q;
    logic              fault_q;

    logic latch, cap0, cap1;

    function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a;
        endcase
    endfunction

    function automatic logic req_fault(input logic st, input logic [2:0] f3, input logic [2:0] a);
        logic f;
        f = 1'b0;
        if (f3[1:0] == 2'd3 && DATA_W == 32) f = 1'b1;
        if (st && f3[2])                     f = 1'b1;
        if (f3 == 3'b111)                    f = 1'b1;
        if (!SPLIT_EN && is_misaligned(a, f3[1:0])) f = 1'b1;
        return f;
    endfunction

    function automatic logic [2*NB-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return (2*NB)'(8'h01);
            2'd1:    return (2*NB)'(8'h03);
            2'd2:    return (2*NB)'(8'h0F);
            default: return (2*NB)'(8'hFF);
        endcase
    endfunction

    // Keep the low 2^sz bytes, then sign- or zero-fill the rest of the word.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input logic [1:0] sz, input logic uns);
        int                       nbits;
        int                       sh;
        logic [DATA_W-1:0]        keep;
        logic signed [DATA_W-1:0] sv;
        nbits = 8 << sz;
        sh    = (nbits >= DATA_W) ? 0 : DATA_W - nbits;
        keep  = {DATA_W{1'b1}} >> sh;
        sv    = signed'(v << sh) >>> sh;
        return uns ? (v & keep) : sv;
    endfunction

    logic [OFF_W-1:0]    off;
    logic [SPN_W-1:0]    span;
    logic                split;
    logic [2*NB-1:0]     be_wide;
    logic [2*DATA_W-1:0] wd_wide;
    logic [2*DATA_W-1:0] rd_cat;
    logic [ADDR_W-1:0]   base_addr;

    assign off       = addr_q[OFF_W-1:0];
    assign span      = SPN_W'(off) + (SPN_W'(1) << funct3_q[1:0]);
    assign split     = SPLIT_EN && (span > SPN_W'(NB));
    assign be_wide   = size_mask(funct3_q[1:0]) << off;
    assign wd_wide   = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
    assign rd_cat    = {beat1_q, beat0_q} >> {off, 3'b000};
    assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Strobes are gated with rst so an abandoned access releases the bus at once.
    always_comb begin
        state_d             = state_q;
        latch               = 1'b0;
        cap0                = 1'b0;
        cap1                = 1'b0;
        bus.req_ready       = 1'b0;
        bus.rsp_valid       = 1'b0;
        bus.rsp_rdata       = '0;
        bus.rsp_fault       = 1'b0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_addr        = '0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    latch   = 1'b1;
                    state_d = req_fault(bus.req_store, bus.req_funct3, bus.req_addr[2:0]) ? RESP : ACC1;
                end
            end
            ACC1: begin
                bus.mem_read        = !store_q && !rst;
                bus.mem_write       = store_q && !rst;
                bus.mem_addr        = base_addr;
                bus.mem_byte_enable = be_wide[NB-1:0];
                bus.mem_wdata       = wd_wide[DATA_W-1:0];
                if (bus.mem_resp) begin
                    cap0    = 1'b1;
                    state_d = split ? ACC2 : RESP;
                end
            end
            ACC2: begin
                bus.mem_read        = !store_q && !rst;
                bus.mem_write       = store_q && !rst;
                bus.mem_addr        = base_addr + ADDR_W'(NB);
                bus.mem_byte_enable = be_wide[2*NB-1:NB];
                bus.mem_wdata       = wd_wide[2*DATA_W-1:DATA_W];
                if (bus.mem_resp) begin
                    cap1    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_fault = fault_q;
                if (!fault_q && !store_q)
                    bus.rsp_rdata = extend(rd_cat[DATA_W-1:0], funct3_q[1:0], funct3_q[2]);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
            beat0_q  <= '0;
            beat1_q  <= '0;
        end else begin
            if (latch) begin
                store_q  <= bus.req_store;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                fault_q  <= req_fault(bus.req_store, bus.req_funct3, bus.req_addr[2:0]);
            end
            if (cap0) beat0_q <= bus.mem_rdata;
            if (cap1) beat1_q <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl at DATA_W=32 and DATA_W=64; responses are checked by a
// scoreboard monitor, memory-side lanes and strobes by the driver.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
    lsu_ctrl_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

    lsu_ctrl #(.DATA_W(32), .ADDR_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    lsu_ctrl #(.DATA_W(64), .ADDR_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

    logic        cur;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_resp;
    logic [63:0] mem_rdata;

    assign b32.req_valid  = req_valid && !cur;
    assign b32.req_store  = req_store;
    assign b32.req_funct3 = req_funct3;
    assign b32.req_addr   = req_addr;
    assign b32.req_wdata  = req_wdata[31:0];
    assign b32.mem_resp   = mem_resp && !cur;
    assign b32.mem_rdata  = mem_rdata[31:0];
    assign b64.req_valid  = req_valid && cur;
    assign b64.req_store  = req_store;
    assign b64.req_funct3 = req_funct3;
    assign b64.req_addr   = req_addr;
    assign b64.req_wdata  = req_wdata;
    assign b64.mem_resp   = mem_resp && cur;
    assign b64.mem_rdata  = mem_rdata;

    logic        s_ready, s_read, s_write;
    logic [31:0] s_addr;
    logic [7:0]  s_be;
    logic [63:0] s_wdata;

    always_comb begin
        if (cur) begin
            s_ready = b64.req_ready;
            s_read  = b64.mem_read;
            s_write = b64.mem_write;
            s_addr  = b64.mem_addr;
            s_be    = b64.mem_byte_enable;
            s_wdata = b64.mem_wdata;
        end else begin
            s_ready = b32.req_ready;
            s_read  = b32.mem_read;
            s_write = b32.mem_write;
            s_addr  = b32.mem_addr;
            s_be    = {4'b0, b32.mem_byte_enable};
            s_wdata = {32'b0, b32.mem_wdata};
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        sel;
        logic [63:0] rd;
        logic        f;
        int          cyc;
        int          id;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic score(input logic sel, input logic [63:0] rd, input logic f);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got rsp_valid on dut%0d expected none", sel ? 64 : 32);
            return;
        end
        e = q.pop_front();
        chk($sformatf("t%0d_rsp_dut", e.id), {63'b0, sel}, {63'b0, e.sel});
        chk($sformatf("t%0d_rsp_rdata", e.id), rd, e.rd);
        chk($sformatf("t%0d_rsp_fault", e.id), {63'b0, f}, {63'b0, e.f});
        chk($sformatf("t%0d_rsp_cycle", e.id), 64'(cyc), 64'(e.cyc));
    endtask

    always @(negedge clk) begin
        if (b32.rsp_valid) score(1'b0, {32'b0, b32.rsp_rdata}, b32.rsp_fault);
        if (b64.rsp_valid) score(1'b1, b64.rsp_rdata, b64.rsp_fault);
    end

    task automatic run(input int id, input logic sel, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd, input int nb,
                       input logic [31:0] a0, input logic [7:0] be0, input logic [63:0] wd0,
                       input logic [63:0] rd0, input int w0,
                       input logic [31:0] a1, input logic [7:0] be1, input logic [63:0] wd1,
                       input logic [63:0] rd1, input int w1,
                       input logic [63:0] exp_rd, input logic exp_f, input int lat);
        exp_t e;
        cur = sel;
        @(negedge clk);
        chk($sformatf("t%0d_ready_idle", id), {63'b0, s_ready}, 64'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        e.sel = sel; e.rd = exp_rd; e.f = exp_f; e.cyc = cyc + lat; e.id = id;
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            int w;
            w = (b == 0) ? w0 : w1;
            for (int k = 0; k <= w; k++) begin
                chk($sformatf("t%0d_b%0d_strobes", id, b), {62'b0, s_read, s_write}, {62'b0, !st, st});
                if (k == 0) begin
                    chk($sformatf("t%0d_b%0d_addr", id, b), {32'b0, s_addr}, {32'b0, (b == 0) ? a0 : a1});
                    chk($sformatf("t%0d_b%0d_be", id, b), {56'b0, s_be}, {56'b0, (b == 0) ? be0 : be1});
                    chk($sformatf("t%0d_b%0d_wdata", id, b), s_wdata, (b == 0) ? wd0 : wd1);
                end
                if (k == w) begin
                    mem_resp  = 1'b1;
                    mem_rdata = (b == 0) ? rd0 : rd1;
                end
                @(negedge clk);
                mem_resp = 1'b0;
            end
        end
        chk($sformatf("t%0d_resp_strobes", id), {62'b0, s_read, s_write}, 64'd0);
        chk($sformatf("t%0d_resp_ready", id), {63'b0, s_ready}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cur = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
        #1;
        chk("reset_ready32", {63'b0, b32.req_ready}, 64'd1);
        chk("reset_ready64", {63'b0, b64.req_ready}, 64'd1);
        chk("reset_strobes32", {60'b0, b32.mem_read, b32.mem_write, b32.rsp_valid, b32.rsp_fault}, 64'd0);
        chk("reset_strobes64", {60'b0, b64.mem_read, b64.mem_write, b64.rsp_valid, b64.rsp_fault}, 64'd0);
        chk("reset_bus32", {b32.mem_addr, b32.mem_wdata} | {32'b0, b32.rsp_rdata}
                           | {60'b0, b32.mem_byte_enable}, 64'd0);
        chk("reset_bus64", b64.mem_wdata | b64.rsp_rdata | {32'b0, b64.mem_addr}
                           | {56'b0, b64.mem_byte_enable}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 32-bit bus
        run(1, 0, 0, 3'b010, 32'h100, 0, 1, 32'h100, 8'h0F, 0, 64'hDEADBEEF, 2,
            0, 0, 0, 0, 0, 64'hDEADBEEF, 0, 4);
        run(2, 0, 0, 3'b000, 32'h103, 0, 1, 32'h100, 8'h08, 0, 64'h80000000, 0,
            0, 0, 0, 0, 0, 64'hFFFFFF80, 0, 2);
        run(3, 0, 0, 3'b100, 32'h103, 0, 1, 32'h100, 8'h08, 0, 64'h80000000, 0,
            0, 0, 0, 0, 0, 64'h00000080, 0, 2);
        run(4, 0, 1, 3'b001, 32'h102, 64'h1234ABCD, 1, 32'h100, 8'h0C, 64'hABCD0000, 64'hFFFFFFFF, 0,
            0, 0, 0, 0, 0, 64'h0, 0, 2);
`ifdef MISALIGN_SPLIT_EN
        run(5, 0, 0, 3'b010, 32'h103, 0, 2, 32'h100, 8'h08, 0, 64'h44000000, 0,
            32'h104, 8'h07, 0, 64'h00112233, 0, 64'h11223344, 0, 3);
        run(11, 0, 0, 3'b001, 32'h101, 0, 1, 32'h100, 8'h06, 0, 64'h00ABCD00, 0,
            0, 0, 0, 0, 0, 64'hFFFFABCD, 0, 2);
`else
        run(5, 0, 0, 3'b010, 32'h103, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1);
        run(11, 0, 0, 3'b001, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1);
`endif
        run(6, 0, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1);
        run(7, 0, 0, 3'b111, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1);
        run(8, 0, 1, 3'b100, 32'h100, 64'hA5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1);
        run(9, 0, 0, 3'b001, 32'h102, 0, 1, 32'h100, 8'h0C, 0, 64'h80010000, 1,
            0, 0, 0, 0, 0, 64'hFFFF8001, 0, 3);
        run(10, 0, 0, 3'b101, 32'h102, 0, 1, 32'h100, 8'h0C, 0, 64'h80010000, 0,
            0, 0, 0, 0, 0, 64'h00008001, 0, 2);
        run(12, 0, 1, 3'b010, 32'h104, 64'hCAFEF00D, 1, 32'h104, 8'h0F, 64'hCAFEF00D, 64'h0, 0,
            0, 0, 0, 0, 0, 64'h0, 0, 2);
        run(13, 0, 1, 3'b000, 32'h101, 64'hA5, 1, 32'h100, 8'h02, 64'h0000A500, 64'h0, 0,
            0, 0, 0, 0, 0, 64'h0, 0, 2);

        // Reset pulsed during ACC1 abandons the load without a response
        cur = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = '0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t14_acc1_read", {63'b0, s_read}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t14_rst_read", {63'b0, s_read}, 64'd0);
        chk("t14_rst_ready", {63'b0, s_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run(15, 0, 0, 3'b010, 32'h100, 0, 1, 32'h100, 8'h0F, 0, 64'h0BADF00D, 0,
            0, 0, 0, 0, 0, 64'h0BADF00D, 0, 2);

        // 64-bit bus
        run(16, 1, 0, 3'b011, 32'h8, 0, 1, 32'h8, 8'hFF, 0, 64'h0123456789ABCDEF, 0,
            0, 0, 0, 0, 0, 64'h0123456789ABCDEF, 0, 2);
        run(17, 1, 0, 3'b010, 32'hC, 0, 1, 32'h8, 8'hF0, 0, 64'h8765432100000000, 0,
            0, 0, 0, 0, 0, 64'hFFFFFFFF87654321, 0, 2);
        run(18, 1, 0, 3'b110, 32'hC, 0, 1, 32'h8, 8'hF0, 0, 64'h8765432100000000, 0,
            0, 0, 0, 0, 0, 64'h0000000087654321, 0, 2);
        run(19, 1, 1, 3'b011, 32'h10, 64'h1122334455667788, 1, 32'h10, 8'hFF, 64'h1122334455667788,
            64'h0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 2);
        run(20, 1, 0, 3'b111, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1);
        run(22, 1, 1, 3'b001, 32'h6, 64'hBEEF, 1, 32'h0, 8'hC0, 64'hBEEF000000000000, 64'h0, 0,
            0, 0, 0, 0, 0, 64'h0, 0, 2);
`ifdef MISALIGN_SPLIT_EN
        run(21, 1, 0, 3'b011, 32'hC, 0, 2, 32'h8, 8'hF0, 0, 64'h89ABCDEF00000000, 0,
            32'h10, 8'h0F, 0, 64'h0000000001234567, 0, 64'h0123456789ABCDEF, 0, 3);
`else
        run(21, 1, 0, 3'b011, 32'hC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1);
`endif

        repeat (3) @(negedge clk);
        chk("drain_pending", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
